// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter tenure controller.
// Optional feature macro used by the top: GRANT_STATS_EN.
package arb_pkg;

  localparam int DEF_NREQ  = 3;
  localparam int DEF_LEN_W = 4;
  localparam int OWNER_W   = $clog2(DEF_NREQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TENURE  = 2'd1,
    RELEASE = 2'd2
  } tenure_state_e;

  typedef struct packed {
    logic               onehot;
    logic [OWNER_W-1:0] idx;
  } oh_res_t;

  // Index of the set bit plus a flag that exactly one bit is set.
  // idx is only meaningful when onehot is 1.
  function automatic oh_res_t onehot_idx(input logic [DEF_NREQ-1:0] v);
    oh_res_t     r;
    int unsigned n;
    r = '0;
    n = 0;
    for (int i = 0; i < DEF_NREQ; i++) begin
      if (v[i]) begin
        n++;
        r.idx = OWNER_W'(i);
      end
    end
    r.onehot = (n == 1);
    return r;
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// CNT_W-bit counter that increments on inc_i and holds at all-ones.
module arb_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: step up unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/arb_tenure_ctrl.sv
// Turns arbiter grants into bounded bus tenures: latches the owner, counts
// beats, pulses done/abort and waits for grant release before re-arming.
// Optional per-requester completion counters: define GRANT_STATS_EN.
module arb_tenure_ctrl
  import arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [NREQ-1:0]         grant_i,
  input  logic [LEN_W-1:0]        len_i,
  input  logic                    beat_valid_i,
  output logic                    beat_ready_o,
  output logic [$clog2(NREQ)-1:0] owner_o,
  output logic                    owner_vld_o,
  output logic [NREQ-1:0]         done_o,
  output logic                    abort_o,
  output logic                    err_multi_o,
  output logic [NREQ*CNT_W-1:0]   grant_cnt_o
);

  localparam int OW = $clog2(NREQ);

  tenure_state_e    state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;

  oh_res_t oh;
  logic    multi;

  assign oh    = onehot_idx(grant_i);
  assign multi = (|grant_i) && !oh.onehot;

  // Next-state and pulse generation; the owner's grant is checked before
  // the beat, so a drop on the last beat aborts rather than completes.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beats_d = beats_q;
    done_d  = '0;
    abort_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (oh.onehot) begin
          owner_d = oh.idx;
          beats_d = len_i;
          state_d = TENURE;
        end else if (multi) begin
          err_d = 1'b1;
        end
      end
      TENURE: begin
        if (!grant_i[owner_q]) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (beat_valid_i) begin
          if (beats_q == '0) begin
            done_d  = NREQ'(1) << owner_q;
            state_d = RELEASE;
          end else begin
            beats_d = beats_q - 1'b1;
          end
        end
      end
      RELEASE: begin
        if (!grant_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      beats_q <= '0;
      done_q  <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beats_q <= beats_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  assign beat_ready_o = (state_q == TENURE);
  assign owner_vld_o  = (state_q == TENURE);
  assign owner_o      = owner_q;
  assign done_o       = done_q;
  assign abort_o      = abort_q;
  assign err_multi_o  = err_q;

`ifdef GRANT_STATS_EN
  // One saturating completion counter per requester, bumped by its done.
  for (genvar i = 0; i < NREQ; i++) begin : g_stats
    arb_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .inc_i   (done_q[i]),
      .cnt_o   (grant_cnt_o[i*CNT_W +: CNT_W])
    );
  end
`else
  assign grant_cnt_o = '0;
`endif

endmodule
